rv32i_mc_core: RTL and testbench

Multi-cycle RV32I core: next generation of the single-cycle `rv32i_cpu`. It runs one instruction through a FETCH/EXEC/MEM/WB state machine over separate instruction and data buses with valid/ready handshakes, so memories and the UART may insert wait states. It has a parametrised reset vector, byte-enable stores, and precise halting on ECALL/EBREAK, illegal opcodes and misalignment. It replaces `rv32i_cpu` at the top level; the register file and ALU are internal.

---
 rtl/rv32i_mc_core_if.sv | 28 ++
 rtl/rv32i_mc_core.sv | 189 ++++++++++++++++++
 tb/tb_rv32i_mc_core.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_mc_core_if.sv
// Instruction and data bus bundle for rv32i_mc_core.
// Ports: imem_req/imem_addr -> imem_ready/imem_rdata (fetch side);
//        dmem_req/we/be/addr/wdata -> dmem_ready/dmem_rdata (data side).
interface rv32i_mc_core_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, input imem_ready, imem_rdata,
    output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, output imem_ready, imem_rdata,
    input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/rv32i_mc_core.sv
// Multi-cycle RV32I core: FETCH -> EXEC -> (MEM) -> WB, halting on ECALL/EBREAK, illegal or misaligned.
// Ports: clk, rst (async, active-high), bus (master side of rv32i_mc_core_if),
//        pc, retire (pulse per retired instruction), halted / halt_cause (0 ecall/ebreak, 1 illegal, 2 misaligned).
module rv32i_mc_core #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter bit          TRAP_MISALIGN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  rv32i_mc_core_if.master        bus,
  output logic [31:0]            pc,
  output logic                   retire,
  output logic                   halted,
  output logic [1:0]             halt_cause
);
  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL  = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BR   = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG  = 7'b0110011,
                         OP_FENCE = 7'b0001111, OP_SYS = 7'b1110011;

  state_t      state, state_nx;
  logic [31:0] instr;
  logic [31:0] rf [0:31];
  logic [31:0] res_q, npc_q, addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic [1:0]  cause_nx;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] alu_b, alu, addr, target, result, wdata, ld_sh, ld_val;
  logic [1:0]  off;
  logic [3:0]  be;
  logic        legal, is_sys, is_mem, is_store, wr_rd, taken, cond, mis;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign rd    = instr[11:7];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];
  assign rs1_v = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_v = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Decode / execute datapath; only sampled while the FSM sits in EXEC.
  always_comb begin
    legal = 1'b0; is_sys = 1'b0; is_mem = 1'b0; is_store = 1'b0;
    wr_rd = 1'b0; taken = 1'b0; result = 32'd0; target = pc + imm_b;
    alu_b = (opc == OP_REG) ? rs2_v : imm_i;
    case (f3)
      3'd0:    alu = (opc == OP_REG && f7[5]) ? rs1_v - alu_b : rs1_v + alu_b;
      3'd1:    alu = rs1_v << alu_b[4:0];
      3'd2:    alu = {31'd0, $signed(rs1_v) < $signed(alu_b)};
      3'd3:    alu = {31'd0, rs1_v < alu_b};
      3'd4:    alu = rs1_v ^ alu_b;
      3'd5:    alu = f7[5] ? 32'($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
      3'd6:    alu = rs1_v | alu_b;
      default: alu = rs1_v & alu_b;
    endcase
    case (f3)
      3'd0:    cond = (rs1_v == rs2_v);
      3'd1:    cond = (rs1_v != rs2_v);
      3'd4:    cond = $signed(rs1_v) <  $signed(rs2_v);
      3'd5:    cond = $signed(rs1_v) >= $signed(rs2_v);
      3'd6:    cond = rs1_v <  rs2_v;
      3'd7:    cond = rs1_v >= rs2_v;
      default: cond = 1'b0;
    endcase
    addr = rs1_v + ((opc == OP_STORE) ? imm_s : imm_i);
    case (opc)
      OP_LUI:   begin legal = 1'b1; wr_rd = 1'b1; result = imm_u; end
      OP_AUIPC: begin legal = 1'b1; wr_rd = 1'b1; result = pc + imm_u; end
      OP_JAL:   begin legal = 1'b1; wr_rd = 1'b1; result = pc + 32'd4; taken = 1'b1; target = pc + imm_j; end
      OP_JALR:  begin
        legal = (f3 == 3'd0); wr_rd = 1'b1; result = pc + 32'd4; taken = 1'b1;
        target = (rs1_v + imm_i) & ~32'd1;
      end
      OP_BR:    begin legal = (f3 != 3'd2) && (f3 != 3'd3); taken = cond; end
      OP_LOAD:  begin legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7); is_mem = 1'b1; wr_rd = 1'b1; end
      OP_STORE: begin legal = (f3 < 3'd3); is_mem = 1'b1; is_store = 1'b1; end
      OP_IMM:   begin
        legal  = (f3 == 3'd1) ? (f7 == 7'd0) :
                 (f3 == 3'd5) ? (f7 == 7'd0 || f7 == 7'b0100000) : 1'b1;
        wr_rd  = 1'b1; result = alu;
      end
      OP_REG:   begin
        legal  = (f7 == 7'd0) || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5));
        wr_rd  = 1'b1; result = alu;
      end
      OP_FENCE: legal = 1'b1;
      // Only ECALL (imm 0) and EBREAK (imm 1) with all other fields zero are accepted.
      OP_SYS:   begin is_sys = (instr[31:7] == 25'd0) || (instr[31:7] == 25'h0002000); legal = is_sys; end
      default:  legal = 1'b0;
    endcase
    // Lane offset: misaligned halves/words are forced onto their natural boundary,
    // which only matters when misalignment does not trap.
    off = (f3[1:0] == 2'd2) ? 2'd0 : (f3[1:0] == 2'd1) ? {addr[1], 1'b0} : addr[1:0];
    mis = TRAP_MISALIGN &&
          ((is_mem && ((f3[1:0] == 2'd2 && addr[1:0] != 2'd0) || (f3[1:0] == 2'd1 && addr[0]))) ||
           (taken && target[1:0] != 2'd0));
    case (f3[1:0])
      2'd0:    begin be = 4'b0001 << off; wdata = {4{rs2_v[7:0]}}; end
      2'd1:    begin be = off[1] ? 4'b1100 : 4'b0011; wdata = {2{rs2_v[15:0]}}; end
      default: begin be = 4'b1111; wdata = rs2_v; end
    endcase
  end

  // Load lane extraction from the word returned in MEM.
  always_comb begin
    ld_sh = bus.dmem_rdata >> {addr_q[1:0], 3'b000};
    case (f3)
      3'd0:    ld_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'd1:    ld_val = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'd4:    ld_val = {24'd0, ld_sh[7:0]};
      3'd5:    ld_val = {16'd0, ld_sh[15:0]};
      default: ld_val = ld_sh;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cause_nx = 2'd0;
    case (state)
      S_FETCH: if (bus.imem_ready) state_nx = S_EXEC;
      S_EXEC: begin
        if (!legal)      begin state_nx = S_HALT; cause_nx = 2'd1; end
        else if (is_sys) begin state_nx = S_HALT; cause_nx = 2'd0; end
        else if (mis)    begin state_nx = S_HALT; cause_nx = 2'd2; end
        else if (is_mem) state_nx = S_MEM;
        else             state_nx = S_WB;
      end
      S_MEM:   if (bus.dmem_ready) state_nx = S_WB;
      S_WB:    state_nx = S_FETCH;
      default: state_nx = S_HALT;
    endcase
  end

  // Reset holds the state at FETCH, so the fetch request is also masked by rst itself.
  assign bus.imem_req   = (state == S_FETCH) && !rst;
  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = (state == S_MEM);
  assign bus.dmem_we    = (state == S_MEM) && we_q;
  assign bus.dmem_be    = ((state == S_MEM) && we_q) ? be_q : 4'd0;
  assign bus.dmem_addr  = {addr_q[31:2], 2'b00};
  assign bus.dmem_wdata = wdata_q;
  assign retire         = (state == S_WB);
  assign halted         = (state == S_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC; instr <= 32'd0; halt_cause <= 2'd0;
      res_q <= 32'd0; npc_q <= 32'd0; addr_q <= 32'd0; wdata_q <= 32'd0; be_q <= 4'd0; we_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      case (state)
        S_FETCH: if (bus.imem_ready) instr <= bus.imem_rdata;
        S_EXEC: begin
          res_q   <= result;
          npc_q   <= taken ? {target[31:2], 2'b00} : pc + 32'd4;
          addr_q  <= {addr[31:2], off};
          be_q    <= be;
          wdata_q <= wdata;
          we_q    <= is_store;
          if (state_nx == S_HALT) halt_cause <= cause_nx;
        end
        S_MEM: if (bus.dmem_ready && !we_q) res_q <= ld_val;
        S_WB: begin
          pc <= npc_q;
          if (wr_rd && rd != 5'd0) rf[rd] <= res_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32i_mc_core.sv
// Directed bench for rv32i_mc_core: drives the instruction/data buses cycle by cycle,
// queues expected data-bus transactions as instructions are issued and checks them when requested.
// Register values are observed by storing them to address 0 and checking the store data.
module tb_rv32i_mc_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc;
  logic        retire, halted;
  logic [1:0]  halt_cause;
  int          tests = 0;
  int          fails = 0;
  int          cyc;
  logic [31:0] mpc;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } dreq_t;
  dreq_t sb_q[$];

  rv32i_mc_core_if bus();

  rv32i_mc_core #(.RESET_PC(32'h100), .TRAP_MISALIGN(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus), .pc(pc), .retire(retire),
    .halted(halted), .halt_cause(halt_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FETCH (with optional wait states) and EXEC; returns positioned in the cycle after EXEC.
  task automatic fetch(input logic [31:0] instr, input int iwait);
    chk("imem_req", {31'd0, bus.imem_req}, 32'd1);
    chk("imem_addr", bus.imem_addr, mpc);
    for (int w = 0; w < iwait; w++) begin
      bus.imem_ready = 1'b0;
      tick(); cyc++;
      chk("imem_req_hold", {31'd0, bus.imem_req}, 32'd1);
      chk("imem_addr_hold", bus.imem_addr, mpc);
    end
    bus.imem_ready = 1'b1;
    bus.imem_rdata = instr;
    tick(); cyc++;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;
    tick(); cyc++;
  endtask

  task automatic run(input logic [31:0] instr, input int iwait, input int dwait,
                     input logic [31:0] rdata, input int exp_cyc, input logic [31:0] exp_pc);
    dreq_t e;
    cyc = 1;
    fetch(instr, iwait);
    if (bus.dmem_req) begin
      chk("dmem_expected", sb_q.size(), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("dmem_addr", bus.dmem_addr, e.addr);
        chk("dmem_we", {31'd0, bus.dmem_we}, {31'd0, e.we});
        chk("dmem_be", {28'd0, bus.dmem_be}, {28'd0, e.be});
        if (e.we) chk("dmem_wdata", bus.dmem_wdata, e.wdata);
      end
      for (int w = 0; w < dwait; w++) begin
        bus.dmem_ready = 1'b0;
        tick(); cyc++;
        chk("dmem_req_hold", {31'd0, bus.dmem_req}, 32'd1);
        chk("dmem_addr_hold", bus.dmem_addr, e.addr);
      end
      bus.dmem_ready = 1'b1;
      bus.dmem_rdata = rdata;
      tick(); cyc++;
      bus.dmem_ready = 1'b0;
      bus.dmem_rdata = 32'h0;
    end else if (sb_q.size() != 0) begin
      chk("dmem_req_missing", {31'd0, bus.dmem_req}, 32'd1);
      void'(sb_q.pop_front());
    end
    chk("retire", {31'd0, retire}, 32'd1);
    chk("cycles", cyc, exp_cyc);
    tick();
    chk("retire_pulse", {31'd0, retire}, 32'd0);
    chk("pc", pc, exp_pc);
    mpc = exp_pc;
  endtask

  task automatic run_halt(input logic [31:0] instr, input logic [1:0] cause);
    cyc = 1;
    fetch(instr, 0);
    chk("halted", {31'd0, halted}, 32'd1);
    chk("halt_cause", {30'd0, halt_cause}, {30'd0, cause});
    chk("halt_no_dmem", {31'd0, bus.dmem_req}, 32'd0);
    chk("halt_no_retire", {31'd0, retire}, 32'd0);
    tick(); tick();
    chk("halt_no_fetch", {31'd0, bus.imem_req}, 32'd0);
    chk("halt_pc", pc, mpc);
    chk("halt_held", {31'd0, halted}, 32'd1);
  endtask

  // Observe register r through "sw xr,0(x0)".
  task automatic chk_reg(input logic [4:0] r, input logic [31:0] v);
    sb_q.push_back('{addr: 32'h0, we: 1'b1, be: 4'hF, wdata: v});
    run(enc_s(32'd0, r, 5'd0, 3'd2), 0, 0, 32'd0, 4, mpc + 32'd4);
  endtask

  task automatic push_ld(input logic [31:0] a);
    sb_q.push_back('{addr: a, we: 1'b0, be: 4'h0, wdata: 32'h0});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    tick(); tick();
    chk("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_dmem_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("rst_pc", pc, 32'h100);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    rst = 1'b0;
    #1;
    mpc = 32'h100;
  endtask

  logic [31:0] link;

  initial begin
    bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0;
    bus.dmem_ready = 1'b0; bus.dmem_rdata = 32'h0;
    mpc = 32'h100;
    tick(); tick();
    chk("rst_dmem_we", {31'd0, bus.dmem_we}, 32'd0);
    chk("rst_dmem_be", {28'd0, bus.dmem_be}, 32'd0);
    chk("rst_retire", {31'd0, retire}, 32'd0);
    chk("rst_halt_cause", {30'd0, halt_cause}, 32'd0);
    do_reset();

    run(enc_i(32'd5, 5'd0, 3'd0, 5'd1, 7'b0010011), 0, 0, 0, 3, 32'h104);   // addi x1,x0,5
    chk_reg(5'd1, 32'd5);
    run(enc_r(7'd0, 5'd1, 5'd1, 3'd0, 5'd7), 3, 0, 0, 6, mpc + 4);          // add x7,x1,x1 (3 waits)
    chk_reg(5'd7, 32'd10);

    run({20'h00001, 5'd2, 7'b0110111}, 0, 0, 0, 3, mpc + 4);               // lui x2,1
    run(enc_i(32'hA5, 5'd0, 3'd0, 5'd3, 7'b0010011), 0, 0, 0, 3, mpc + 4); // addi x3,x0,0xA5
    sb_q.push_back('{addr: 32'h1000, we: 1'b1, be: 4'b1000, wdata: 32'hA5A5_A5A5});
    run(enc_s(32'd3, 5'd3, 5'd2, 3'd0), 0, 2, 0, 6, mpc + 4);               // sb x3,3(x2), 2 waits
    push_ld(32'h1000);
    run(enc_i(32'd3, 5'd2, 3'd0, 5'd4, 7'b0000011), 0, 0, 32'hA500_0000, 4, mpc + 4); // lb
    chk_reg(5'd4, 32'hFFFF_FFA5);
    push_ld(32'h1000);
    run(enc_i(32'd3, 5'd2, 3'd4, 5'd4, 7'b0000011), 0, 1, 32'hA500_0000, 5, mpc + 4); // lbu
    chk_reg(5'd4, 32'h0000_00A5);
    sb_q.push_back('{addr: 32'h1000, we: 1'b1, be: 4'b1100, wdata: 32'h00A5_00A5});
    run(enc_s(32'd2, 5'd3, 5'd2, 3'd1), 0, 0, 0, 4, mpc + 4);               // sh x3,2(x2)
    push_ld(32'h1000);
    run(enc_i(32'd2, 5'd2, 3'd1, 5'd8, 7'b0000011), 0, 0, 32'h8001_0000, 4, mpc + 4); // lh x8,2(x2)
    chk_reg(5'd8, 32'hFFFF_8001);

    run(enc_i(32'hFFFF_FFFF, 5'd0, 3'd0, 5'd5, 7'b0010011), 0, 0, 0, 3, mpc + 4); // x5=-1
    run(enc_i(32'd1, 5'd0, 3'd0, 5'd6, 7'b0010011), 0, 0, 0, 3, mpc + 4);         // x6=1
    run(enc_b(32'd8, 5'd6, 5'd5, 3'd4), 0, 0, 0, 3, mpc + 8);               // blt taken
    run(enc_b(32'd8, 5'd6, 5'd5, 3'd6), 0, 0, 0, 3, mpc + 4);               // bltu not taken
    link = mpc + 32'd4;
    run(enc_j(32'hFFFF_FFFC, 5'd1), 0, 0, 0, 3, mpc - 4);                   // jal x1,-4
    chk_reg(5'd1, link);
    run(enc_r(7'b0100000, 5'd5, 5'd6, 3'd0, 5'd9), 0, 0, 0, 3, mpc + 4);    // sub x9,x6,x5
    chk_reg(5'd9, 32'd2);

    run_halt(enc_i(32'd2, 5'd2, 3'd2, 5'd11, 7'b0000011), 2'd2);            // lw at 0x1002
    do_reset();
    run_halt(32'h0000_007F, 2'd1);                                         // illegal opcode
    do_reset();
    run_halt(32'h0000_0073, 2'd0);                                         // ecall
    do_reset();

    // Reset while a load is outstanding in MEM.
    cyc = 1;
    fetch(enc_i(32'd0, 5'd0, 3'd2, 5'd12, 7'b0000011), 0);
    chk("mem_req_before_rst", {31'd0, bus.dmem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_drops_dmem_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("rst_mid_pc", pc, 32'h100);
    chk("rst_mid_imem_req", {31'd0, bus.imem_req}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    mpc = 32'h100;
    run(enc_i(32'd7, 5'd0, 3'd0, 5'd1, 7'b0010011), 0, 0, 0, 3, 32'h104);
    chk_reg(5'd1, 32'd7);
    chk_reg(5'd12, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
